// File: rtl/pea_cmd_issuer_pkg.sv
// Shared definitions for the PEA command issuer: opcodes, token field layout,
// FSM state encoding and the log2 helper.
package pea_cmd_issuer_pkg;

  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int unsigned WordSize   = 16;
  localparam int unsigned BufferSize = 1024;
  localparam int unsigned SpaceW     = log2_ceil(BufferSize) + 1;
  localparam int unsigned MaxDegree  = 10;

  localparam logic [7:0] OpStp = 8'd1;
  localparam logic [7:0] OpEvp = 8'd2;
  localparam logic [7:0] OpEvb = 8'd3;
  localparam logic [7:0] OpRst = 8'd5;

  localparam int unsigned OpcodeLsb = 8;
  localparam int unsigned Arg1Lsb   = 5;
  localparam int unsigned Arg2Lsb   = 0;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWaitSpace,
    StSendCmd,
    StSendData
  } state_e;

  typedef logic [5:0] need_t;

  function automatic logic [WordSize-1:0] make_token(input logic [7:0] opcode,
                                                     input logic [2:0] arg1,
                                                     input logic [4:0] arg2);
    logic [WordSize-1:0] tok;
    tok = '0;
    tok[OpcodeLsb +: 8] = opcode;
    tok[Arg1Lsb +: 3]   = arg1;
    tok[Arg2Lsb +: 5]   = arg2;
    return tok;
  endfunction

endpackage

// File: rtl/pea_cmd_issuer_if.sv
// Request, payload and FIFO-side signals of the PEA command issuer.
// master = host/FIFO side, slave = issuer.
interface pea_cmd_issuer_if
  import pea_cmd_issuer_pkg::*;
();
  logic                req_valid;
  logic                req_ready;
  logic [7:0]          req_opcode;
  logic [2:0]          req_arg1;
  logic [4:0]          req_arg2;
  logic                word_valid;
  logic                word_ready;
  logic [WordSize-1:0] word_in;
  logic [SpaceW-1:0]   command_free_space;
  logic [SpaceW-1:0]   data_free_space;
  logic                command_wr_en;
  logic [WordSize-1:0] command_out;
  logic                data_wr_en;
  logic [WordSize-1:0] data_out;

  modport master (
    output req_valid, req_opcode, req_arg1, req_arg2, word_valid, word_in,
           command_free_space, data_free_space,
    input  req_ready, word_ready, command_wr_en, command_out, data_wr_en, data_out
  );

  modport slave (
    input  req_valid, req_opcode, req_arg1, req_arg2, word_valid, word_in,
           command_free_space, data_free_space,
    output req_ready, word_ready, command_wr_en, command_out, data_wr_en, data_out
  );
endinterface

// File: rtl/pea_cmd_decode.sv
// Combinational request decoder: opcode/arg2 -> legality and number of data tokens.
module pea_cmd_decode
  import pea_cmd_issuer_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic [4:0] arg2,
  output logic       legal,
  output need_t      need
);

  always_comb begin
    legal = 1'b0;
    need  = '0;
    case (opcode)
      OpStp: begin
        legal = (arg2 <= 5'(MaxDegree));
        need  = {1'b0, arg2} + 6'd1;
      end
      OpEvp: begin
        legal = 1'b1;
        need  = 6'd1;
      end
      OpEvb: begin
        legal = (arg2 != 5'd0);
        need  = {1'b0, arg2};
      end
      OpRst: begin
        legal = 1'b1;
        need  = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pea_cmd_issuer.sv
// Host-side PEA transmitter: one command token, then its data tokens, issued only
// once both FIFOs have room for the whole packet.
module pea_cmd_issuer
  import pea_cmd_issuer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  pea_cmd_issuer_if.slave bus,
  output logic            busy,
  output logic            req_err
);

  state_e              state_q, state_d;
  logic [7:0]          opcode_q;
  logic [2:0]          arg1_q;
  logic [4:0]          arg2_q;
  need_t               need_q, remaining_q;
  logic                legal;
  need_t               need;
  logic                req_err_q;
  logic                data_wr_en_q;
  logic [WordSize-1:0] data_out_q;
  logic                req_hs, word_hs, space_ok;

  pea_cmd_decode u_decode (
    .opcode (opcode_q),
    .arg2   (arg2_q),
    .legal  (legal),
    .need   (need)
  );

  assign req_hs   = bus.req_valid && bus.req_ready;
  assign word_hs  = bus.word_valid && bus.word_ready;
  assign space_ok = (bus.command_free_space != '0) &&
                    (bus.data_free_space >= SpaceW'(need_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (req_hs) state_d = StCheck;
      StCheck:     state_d = legal ? StWaitSpace : StIdle;
      StWaitSpace: if (space_ok) state_d = StSendCmd;
      StSendCmd:   state_d = (need_q == '0) ? StIdle : StSendData;
      StSendData:  if (word_hs && (remaining_q == 6'd1)) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // req_ready is held low while reset is asserted even though the state is Idle.
  always_comb begin
    bus.req_ready     = 1'b0;
    bus.word_ready    = 1'b0;
    bus.command_wr_en = 1'b0;
    bus.command_out   = '0;
    busy              = (state_q != StIdle);
    unique case (state_q)
      StIdle:     bus.req_ready = rst;
      StSendCmd: begin
        bus.command_wr_en = 1'b1;
        bus.command_out   = make_token(opcode_q, arg1_q, arg2_q);
      end
      StSendData: bus.word_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_q     <= '0;
      arg1_q       <= '0;
      arg2_q       <= '0;
      need_q       <= '0;
      remaining_q  <= '0;
      req_err_q    <= 1'b0;
      data_wr_en_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      req_err_q    <= (state_q == StCheck) && !legal;
      data_wr_en_q <= word_hs;
      if (word_hs) data_out_q <= bus.word_in;
      if (req_hs) begin
        opcode_q <= bus.req_opcode;
        arg1_q   <= bus.req_arg1;
        arg2_q   <= bus.req_arg2;
      end
      if (state_q == StCheck) need_q <= need;
      if (state_q == StSendCmd) remaining_q <= need_q;
      else if (word_hs)         remaining_q <= remaining_q - 6'd1;
    end
  end

  assign bus.data_wr_en = data_wr_en_q;
  assign bus.data_out   = data_out_q;
  assign req_err        = req_err_q;

endmodule

// File: tb/tb_pea_cmd_issuer.sv
// Randomized bench for pea_cmd_issuer with an in-order token model and
// directed packets pinning literal tokens and boundary timing.
module tb_pea_cmd_issuer;
  import pea_cmd_issuer_pkg::*;

  localparam logic [10:0] Ample = 11'd1024;

  typedef struct {
    bit          is_cmd;
    logic [15:0] tok;
    int          need;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, req_err;
  int          total = 0;
  int          bad = 0;
  bit          err_ok = 1'b0;
  exp_t        exp_q[$];
  logic [15:0] wbuf[32];
  int          prev_cmd_sp = 0;
  int          prev_data_sp = 0;

  pea_cmd_issuer_if bus ();

  pea_cmd_issuer dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .req_err (req_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec-level view of a request: is it legal and how many data tokens follow.
  function automatic void model(input logic [7:0] op, input logic [4:0] a2,
                                output bit legal, output int need);
    int d;
    d = int'(a2);
    legal = 1'b0;
    need = 0;
    if (op == 8'd1) begin
      legal = (d <= 10);
      need = d + 1;
    end else if (op == 8'd2) begin
      legal = 1'b1;
      need = 1;
    end else if (op == 8'd3) begin
      legal = (d >= 1);
      need = d;
    end else if (op == 8'd5) begin
      legal = 1'b1;
    end
  endfunction

  // Every FIFO write must match the next expected token, in order.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.command_wr_en || bus.data_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {30'b0, bus.command_wr_en, bus.data_wr_en}, 0);
        end else begin
          e = exp_q.pop_front();
          check("write_kind", {30'b0, bus.command_wr_en, bus.data_wr_en},
                e.is_cmd ? 32'd2 : 32'd1);
          if (e.is_cmd) begin
            check("command_token", {16'b0, bus.command_out}, {16'b0, e.tok});
            check("space_at_issue", {31'b0, (prev_cmd_sp >= 1) && (prev_data_sp >= e.need)}, 1);
          end else begin
            check("data_token", {16'b0, bus.data_out}, {16'b0, e.tok});
          end
        end
      end
      if (req_err) check("req_err_expected", {31'b0, err_ok}, 1);
    end
    prev_cmd_sp  = int'(bus.command_free_space);
    prev_data_sp = int'(bus.data_free_space);
  end

  // short_kind: 0 ample, 1 command FIFO full, 2 data one short, 3 exactly enough.
  task automatic do_request(input logic [7:0] op, input logic [2:0] a1, input logic [4:0] a2,
                            input int short_kind, input int hold, input int first_stall,
                            input int abort_at, input logic [15:0] lit_tok, input bit use_lit);
    logic [15:0] tok;
    bit          legal;
    int          need, lat, n, st;
    bit          hs;
    tok = {op, a1, a2};
    model(op, a2, legal, need);
    n = 0;
    while (!bus.req_ready && n < 100) begin
      step();
      n++;
    end
    check("req_ready_before_accept", {31'b0, bus.req_ready}, 1);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_arg1   = a1;
    bus.req_arg2   = a2;
    bus.command_free_space = 11'(1 + $urandom_range(0, 1));
    bus.data_free_space    = 11'(need + int'($urandom_range(0, 2)));
    if (short_kind == 1) bus.command_free_space = '0;
    else if (short_kind == 2) bus.data_free_space = 11'(need - 1);
    else if (short_kind == 3) begin
      bus.command_free_space = 11'd1;
      bus.data_free_space    = 11'(need);
    end
    step();
    bus.req_valid  = 1'b0;
    bus.req_opcode = 8'($urandom);
    check("busy_in_check", {31'b0, busy}, 1);
    check("req_ready_in_check", {31'b0, bus.req_ready}, 0);
    if (!legal) begin
      err_ok = 1'b1;
      check("req_err_early", {31'b0, req_err}, 0);
      step();
      check("req_err_pulse", {31'b0, req_err}, 1);
      check("idle_after_reject", {31'b0, bus.req_ready}, 1);
      step();
      check("req_err_one_cycle", {31'b0, req_err}, 0);
      err_ok = 1'b0;
      return;
    end
    exp_q.push_back('{1'b1, tok, need});
    for (int i = 0; i < need; i++) exp_q.push_back('{1'b0, wbuf[i], 0});
    lat = 1;
    if (short_kind == 1 || short_kind == 2) begin
      for (int i = 0; i < hold; i++) begin
        step();
        lat++;
        check("held_no_command", {31'b0, bus.command_wr_en}, 0);
      end
      bus.command_free_space = Ample;
      bus.data_free_space    = Ample;
    end
    while (!bus.command_wr_en && lat < 200) begin
      step();
      lat++;
    end
    check("command_seen", {31'b0, bus.command_wr_en}, 1);
    if (short_kind == 0 || short_kind == 3) check("command_latency", lat, 3);
    if (use_lit) check("command_literal", {16'b0, bus.command_out}, {16'b0, lit_tok});
    // Space is already reserved; dropping it now must not stall the payload.
    bus.command_free_space = '0;
    bus.data_free_space    = '0;
    for (int i = 0; i < need; i++) begin
      if (i == 0) st = first_stall;
      else st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      bus.word_valid = 1'b0;
      for (int s = 0; s < st; s++) begin
        step();
        check("word_ready_stall", {31'b0, bus.word_ready}, 1);
      end
      bus.word_valid = 1'b1;
      bus.word_in    = wbuf[i];
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_command_wr_en", {31'b0, bus.command_wr_en}, 0);
        check("abort_data_wr_en", {31'b0, bus.data_wr_en}, 0);
        check("abort_command_out", {16'b0, bus.command_out}, 0);
        check("abort_data_out", {16'b0, bus.data_out}, 0);
        check("abort_word_ready", {31'b0, bus.word_ready}, 0);
        check("abort_req_ready", {31'b0, bus.req_ready}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        exp_q.delete();
        bus.word_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("ready_after_abort", {31'b0, bus.req_ready}, 1);
        return;
      end
      n = 0;
      hs = 1'b0;
      while (!hs && n < 50) begin
        hs = bus.word_ready;
        step();
        n++;
      end
      check("word_accepted", {31'b0, hs}, 1);
      check("data_wr_en_next", {31'b0, bus.data_wr_en}, 1);
      check("data_out_next", {16'b0, bus.data_out}, {16'b0, wbuf[i]});
      bus.word_valid = 1'b0;
    end
    if (need == 0) step();
    check("idle_after_packet", {31'b0, bus.req_ready}, 1);
    check("not_busy_after_packet", {31'b0, busy}, 0);
  endtask

  initial begin
    logic [7:0] op;
    logic [4:0] a2;
    bit         lg;
    int         nd, sk, r;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_opcode = '0;
    bus.req_arg1 = '0;
    bus.req_arg2 = '0;
    bus.word_valid = 1'b0;
    bus.word_in = '0;
    bus.command_free_space = '0;
    bus.data_free_space = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'b0, bus.req_ready}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_command_wr_en", {31'b0, bus.command_wr_en}, 0);
    check("reset_data_wr_en", {31'b0, bus.data_wr_en}, 0);
    check("reset_command_out", {16'b0, bus.command_out}, 0);
    check("reset_data_out", {16'b0, bus.data_out}, 0);
    check("reset_word_ready", {31'b0, bus.word_ready}, 0);
    check("reset_req_err", {31'b0, req_err}, 0);
    rst = 1'b1;
    #1;
    check("req_ready_after_reset", {31'b0, bus.req_ready}, 1);

    wbuf[0] = 16'h0005;
    wbuf[1] = 16'hFFF9;
    wbuf[2] = 16'h0009;
    do_request(8'd1, 3'd3, 5'd2, 0, 0, 0, -1, 16'h0162, 1'b1);
    for (int i = 0; i < 32; i++) wbuf[i] = 16'($urandom);
    do_request(8'd3, 3'd1, 5'd4, 2, 6, 0, -1, 16'h0324, 1'b1);
    do_request(8'd5, 3'd0, 5'd0, 0, 0, 0, -1, 16'h0500, 1'b1);
    do_request(8'd7, 3'd2, 5'd3, 0, 0, 0, -1, 16'h0000, 1'b0);
    do_request(8'd1, 3'd0, 5'd11, 0, 0, 0, -1, 16'h0000, 1'b0);
    wbuf[0] = 16'h8001;
    do_request(8'd2, 3'd4, 5'd0, 0, 0, 5, -1, 16'h0280, 1'b1);
    do_request(8'd1, 3'd0, 5'd10, 3, 0, 0, -1, 16'h010A, 1'b1);
    do_request(8'd1, 3'd2, 5'd3, 0, 0, 0, 1, 16'h0000, 1'b0);
    wbuf[0] = 16'h7FFF;
    do_request(8'd2, 3'd7, 5'd0, 0, 0, 0, -1, 16'h02E0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 5));
      case (r)
        0, 4:    op = 8'd1;
        1:       op = 8'd2;
        2:       op = 8'd3;
        3:       op = 8'd5;
        default: op = ($urandom_range(0, 1) == 0) ? 8'd4 : 8'($urandom_range(6, 255));
      endcase
      a2 = (op == 8'd1) ? 5'($urandom_range(0, 12)) : 5'($urandom_range(0, 31));
      model(op, a2, lg, nd);
      sk = int'($urandom_range(0, 3));
      if (sk == 2 && nd == 0) sk = 1;
      for (int i = 0; i < 32; i++) wbuf[i] = 16'($urandom);
      do_request(op, 3'($urandom), a2, sk, int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 2)), -1, 16'h0000, 1'b0);
    end

    repeat (2) step();
    check("model_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
